// File: rtl/i2c_arb.sv
`default_nettype none
// ============================================================================
// Module   : i2c_arb
// Summary  : Round-robin arbiter that locks one I2C byte engine to a single
//            requester from its first byte until a last byte or an error.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_arb #(
  parameter int N  = 4,
  parameter int OW = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req_i,
  input  logic [8*N-1:0] addr_i,
  input  logic [8*N-1:0] wdata_i,
  input  logic [N-1:0]   last_i,
  output logic [N-1:0]   ack_o,
  output logic [7:0]     rdata_o,
  output logic           err_o,
  output logic           busy_o,
  output logic [OW-1:0]  owner_o,
  output logic [7:0]     i2caddr,
  output logic [7:0]     i2cwdata,
  output logic           i2creq,
  output logic           i2clast,
  input  logic [7:0]     i2crdata,
  input  logic           i2cack,
  input  logic           i2cerr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [OW-1:0] r_ptr;
  logic [OW-1:0] w_ptr_nxt;

  logic [OW-1:0] w_owner_nxt;
  logic [N-1:0]  w_ack_nxt;
  logic [7:0]    w_rdata_nxt;
  logic          w_err_nxt;
  logic          w_busy_nxt;
  logic [7:0]    w_addr_nxt;
  logic [7:0]    w_wdata_nxt;
  logic          w_last_nxt;
  logic          w_req_nxt;

  logic [N-1:0]  w_req_m;
  logic          w_found;
  logic [OW-1:0] w_sel;
  logic [OW-1:0] w_src;
  logic [7:0]    w_src_addr;
  logic [7:0]    w_src_wdata;
  logic          w_src_last;
  logic          w_own_req;
  logic [N-1:0]  w_own_oh;

  function automatic logic [OW-1:0] f_wrap(input int a);
    if (a >= N) return OW'(a - N);
    return OW'(a);
  endfunction

  // A requester that has not yet dropped req in its ack cycle must not reissue.
  assign w_req_m = (ack_o != '0) ? '0 : req_i;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!w_found && w_req_m[k] && (OW'(k) == f_wrap(int'(r_ptr) + i))) begin
          w_found = 1'b1;
          w_sel   = OW'(k);
        end
      end
    end
  end

  always_comb begin
    w_src       = (r_state == S_IDLE) ? w_sel : owner_o;
    w_src_addr  = '0;
    w_src_wdata = '0;
    w_src_last  = 1'b0;
    w_own_req   = 1'b0;
    w_own_oh    = '0;
    for (int k = 0; k < N; k++) begin
      if (OW'(k) == w_src) begin
        w_src_addr  = addr_i[8*k +: 8];
        w_src_wdata = wdata_i[8*k +: 8];
        w_src_last  = last_i[k];
      end
      if (OW'(k) == owner_o) begin
        w_own_req   = w_req_m[k];
        w_own_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = owner_o;
    w_ack_nxt   = '0;
    w_rdata_nxt = rdata_o;
    w_err_nxt   = err_o;
    w_addr_nxt  = i2caddr;
    w_wdata_nxt = i2cwdata;
    w_last_nxt  = i2clast;
    w_req_nxt   = i2creq;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nxt = w_sel;
          w_addr_nxt  = w_src_addr;
          w_wdata_nxt = w_src_wdata;
          w_last_nxt  = w_src_last;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i2cack) begin
          w_req_nxt   = 1'b0;
          w_ack_nxt   = w_own_oh;
          w_rdata_nxt = i2crdata;
          w_err_nxt   = i2cerr;
          if (i2clast || i2cerr) begin
            w_ptr_nxt   = f_wrap(int'(owner_o) + 1);
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_own_req) begin
          w_addr_nxt  = w_src_addr;
          w_wdata_nxt = w_src_wdata;
          w_last_nxt  = w_src_last;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      owner_o  <= '0;
      ack_o    <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
      i2caddr  <= '0;
      i2cwdata <= '0;
      i2clast  <= 1'b0;
      i2creq   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      owner_o  <= w_owner_nxt;
      ack_o    <= w_ack_nxt;
      rdata_o  <= w_rdata_nxt;
      err_o    <= w_err_nxt;
      busy_o   <= w_busy_nxt;
      i2caddr  <= w_addr_nxt;
      i2cwdata <= w_wdata_nxt;
      i2clast  <= w_last_nxt;
      i2creq   <= w_req_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_arb
// Summary  : Self-checking bench for i2c_arb: transaction table, requester and
//            engine models, and an expected-byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_arb;
  localparam int N  = 4;
  localparam int OW = 2;
  localparam logic [7:0] c_rx_xor   = 8'h99;
  localparam logic [7:0] c_err_byte = 8'hEE;

  logic           clk  = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [8*N-1:0] addr_i = '0;
  logic [8*N-1:0] wdata_i = '0;
  logic [N-1:0]   last_i = '0;
  logic [N-1:0]   ack_o;
  logic [7:0]     rdata_o;
  logic           err_o;
  logic           busy_o;
  logic [OW-1:0]  owner_o;
  logic [7:0]     i2caddr;
  logic [7:0]     i2cwdata;
  logic           i2creq;
  logic           i2clast;
  logic [7:0]     i2crdata = '0;
  logic           i2cack = 1'b0;
  logic           i2cerr = 1'b0;

  always #5 clk = ~clk;

  i2c_arb #(.N(N), .OW(OW)) dut (
    .clk(clk), .rstn(rstn),
    .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i), .last_i(last_i),
    .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .owner_o(owner_o),
    .i2caddr(i2caddr), .i2cwdata(i2cwdata), .i2creq(i2creq), .i2clast(i2clast),
    .i2crdata(i2crdata), .i2cack(i2cack), .i2cerr(i2cerr)
  );

  typedef struct packed {
    logic [1:0] k;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       last;
  } byte_t;

  // cnt: bytes per requester (nibble k); ord: owner per engine byte, first in nibble 0
  typedef struct packed {
    logic        rst;
    logic [15:0] cnt;
    logic [7:0]  base;
    logic [3:0]  ek;
    logic [3:0]  eb;
    logic [31:0] ord;
    logic [3:0]  n;
  } vec_t;

  byte_t          pend[$];
  byte_t          exp_q[$];
  byte_t          cur;
  bit             have_cur = 1'b0;
  bit             prev_req = 1'b0;
  bit             eng_en = 1'b1;
  bit             stray_ack = 1'b0;
  bit             hold_ack = 1'b0;
  int             eng_lat = 0;
  int             wcnt = 0;
  logic [N-1:0]   defer_pop = '0;
  logic [N-1:0]   d_req;
  logic [8*N-1:0] d_addr;
  logic [8*N-1:0] d_wdata;
  logic [N-1:0]   d_last;
  int n_pass = 0, n_total = 0, n_issue = 0, n_ack = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
  endtask

  task automatic fail_ev(input string name);
    n_total++;
    $display("FAIL %s: got an event, want none", name);
  endtask

  function automatic byte_t mkb(input int k, input logic [7:0] w, input bit last);
    byte_t b;
    b.k = 2'(k); b.addr = 8'h50 + 8'(k); b.wdata = w; b.last = last;
    return b;
  endfunction

  function automatic logic [7:0] wdat(input vec_t v, input int k, input int b);
    if (k == int'(v.ek) && b == int'(v.eb)) return c_err_byte;
    return v.base + 8'(16*k + b);
  endfunction

  function automatic vec_t mkv(input bit rst, input logic [15:0] cnt, input logic [7:0] base,
                               input logic [3:0] ek, input logic [3:0] eb,
                               input logic [31:0] ord, input logic [3:0] n);
    vec_t v;
    v.rst = rst; v.cnt = cnt; v.base = base; v.ek = ek; v.eb = eb; v.ord = ord; v.n = n;
    return v;
  endfunction

  task automatic pop_req(input int k);
    for (int i = 0; i < pend.size(); i++)
      if (int'(pend[i].k) == k) begin pend.delete(i); break; end
  endtask

  task automatic flush_req(input int k);
    for (int i = pend.size() - 1; i >= 0; i--)
      if (int'(pend[i].k) == k) pend.delete(i);
  endtask

  // Monitor/scoreboard, requester model and engine model, all on the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      have_cur = 1'b0; prev_req = 1'b0; defer_pop = '0; wcnt = 0;
      req_i = '0; addr_i = '0; wdata_i = '0; last_i = '0;
      i2cack = 1'b0; i2cerr = 1'b0;
    end else begin
      if (i2creq && !prev_req) begin
        n_issue++;
        if (exp_q.size() == 0) fail_ev("issue_unexpected");
        else begin
          cur = exp_q[0]; have_cur = 1'b1;
          check("issue_owner", 64'(owner_o), 64'(cur.k));
          check("issue_addr",  64'(i2caddr),  64'(cur.addr));
          check("issue_wdata", 64'(i2cwdata), 64'(cur.wdata));
          check("issue_last",  64'(i2clast),  64'(cur.last));
        end
      end else if (i2creq && have_cur) begin
        check("lines_stable", 64'({i2caddr, i2cwdata, i2clast}), 64'({cur.addr, cur.wdata, cur.last}));
      end
      prev_req = i2creq;
      if (ack_o != '0) begin
        n_ack++;
        if (!have_cur) fail_ev("ack_unexpected");
        else begin
          check("ack_onehot", 64'(ack_o), 64'(4'b0001 << cur.k));
          check("ack_rdata", 64'(rdata_o), 64'(cur.wdata ^ c_rx_xor));
          check("ack_err", 64'(err_o), 64'(cur.wdata == c_err_byte));
          check("ack_busy", 64'(busy_o), 64'(!(cur.last || cur.wdata == c_err_byte)));
          void'(exp_q.pop_front());
          have_cur = 1'b0;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (defer_pop[k]) begin pop_req(k); defer_pop[k] = 1'b0; end
        else if (ack_o[k]) begin
          if (hold_ack) defer_pop[k] = 1'b1;
          else begin pop_req(k); if (err_o) flush_req(k); end
        end
      end
      d_req = '0; d_addr = '0; d_wdata = '0; d_last = '0;
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < pend.size(); i++) begin
          if (int'(pend[i].k) == k) begin
            d_req[k] = 1'b1; d_addr[8*k +: 8] = pend[i].addr;
            d_wdata[8*k +: 8] = pend[i].wdata; d_last[k] = pend[i].last;
            break;
          end
        end
      end
      req_i = d_req; addr_i = d_addr; wdata_i = d_wdata; last_i = d_last;
      if (i2cack) begin
        i2cack = 1'b0; i2cerr = 1'b0;
      end else if (stray_ack) begin
        i2cack = 1'b1; i2crdata = 8'h77; i2cerr = 1'b1; stray_ack = 1'b0;
      end else if (eng_en && i2creq) begin
        if (wcnt >= eng_lat) begin
          i2cack = 1'b1; i2crdata = i2cwdata ^ c_rx_xor;
          i2cerr = (i2cwdata == c_err_byte); wcnt = 0;
        end else wcnt++;
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    pend.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      smp();
      done = (exp_q.size() == 0) && (pend.size() == 0) && !busy_o && !i2creq;
    end
    check(name, 64'(done), 64'(1));
    if (!done) begin pend.delete(); exp_q.delete(); end
  endtask

  task automatic run_vec(input vec_t v);
    int bi [N];
    int kk, b, cn;
    if (v.rst) do_reset();
    sync();
    eng_lat = $urandom_range(0, 2);
    for (int k = 0; k < N; k++) begin
      cn = int'(v.cnt[4*k +: 4]);
      for (int j = 0; j < cn; j++) pend.push_back(mkb(k, wdat(v, k, j), j == cn - 1));
      bi[k] = 0;
    end
    for (int i = 0; i < int'(v.n); i++) begin
      kk = int'(v.ord[4*i +: 4]);
      b = bi[kk]; bi[kk]++;
      cn = int'(v.cnt[4*kk +: 4]);
      exp_q.push_back(mkb(kk, wdat(v, kk, b), b == cn - 1));
    end
    wait_drain("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    int   is0, ak0;
    vt[0] = mkv(1'b1, 16'h0001, 8'hA5, 4'hF, 4'h0, 32'h0000_0000, 4'd1);
    vt[1] = mkv(1'b1, 16'h0110, 8'h10, 4'hF, 4'h0, 32'h0000_0021, 4'd2);
    vt[2] = mkv(1'b0, 16'h0101, 8'h20, 4'hF, 4'h0, 32'h0000_0020, 4'd2);
    vt[3] = mkv(1'b1, 16'h1003, 8'h30, 4'hF, 4'h0, 32'h0000_3000, 4'd4);
    vt[4] = mkv(1'b1, 16'h0130, 8'h40, 4'h1, 4'h0, 32'h0000_0021, 4'd2);
    vt[5] = mkv(1'b1, 16'h2222, 8'h60, 4'hF, 4'h0, 32'h3322_1100, 4'd8);
    vt[6] = mkv(1'b0, 16'h2010, 8'h70, 4'hF, 4'h0, 32'h0000_0331, 4'd3);
    vt[7] = mkv(1'b0, 16'h0202, 8'h80, 4'h0, 4'h1, 32'h0000_2200, 4'd4);

    do_reset();
    smp();
    check("reset_outputs", 64'({ack_o, rdata_o, err_o, busy_o, owner_o}), 64'(0));
    check("reset_engine", 64'({i2creq, i2caddr, i2cwdata, i2clast}), 64'(0));

    // Single write with explicit grant latency and ack timing
    sync(); eng_lat = 0;
    pend.push_back(mkb(0, 8'hA5, 1'b1)); exp_q.push_back(mkb(0, 8'hA5, 1'b1));
    smp(); check("grant_pre", 64'(i2creq), 64'(0));
    smp(); check("grant_req", 64'(i2creq), 64'(1));
    check("grant_lines", 64'({i2caddr, i2cwdata, i2clast}), 64'({8'h50, 8'hA5, 1'b1}));
    smp(); check("w1_ack", 64'(ack_o), 64'(4'b0001));
    check("w1_resp", 64'({rdata_o, err_o, busy_o, i2creq}), 64'({8'h3C, 1'b0, 1'b0, 1'b0}));
    smp(); check("w1_ack_drop", 64'(ack_o), 64'(0));
    check("w1_rdata_hold", 64'(rdata_o), 64'(8'h3C));

    // Engine ack while idle must be ignored
    sync(); stray_ack = 1'b1;
    smp(); smp();
    check("stray_ack", 64'({ack_o, busy_o, i2creq}), 64'(0));
    check("stray_hold", 64'({rdata_o, err_o}), 64'({8'h3C, 1'b0}));

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Requester keeps its byte through the ack cycle
    do_reset(); sync();
    hold_ack = 1'b1; is0 = n_issue; ak0 = n_ack;
    pend.push_back(mkb(0, 8'h5A, 1'b1)); exp_q.push_back(mkb(0, 8'h5A, 1'b1));
    wait_drain("mask_drain");
    repeat (4) smp();
    check("mask_issues", 64'(n_issue - is0), 64'(1));
    check("mask_acks", 64'(n_ack - ak0), 64'(1));
    hold_ack = 1'b0;

    // Reset while a byte is outstanding, after the pointer has moved to 2
    do_reset(); sync();
    pend.push_back(mkb(1, 8'h11, 1'b1)); exp_q.push_back(mkb(1, 8'h11, 1'b1));
    wait_drain("rst_pre_drain");
    sync(); eng_en = 1'b0;
    pend.push_back(mkb(2, 8'h22, 1'b1)); exp_q.push_back(mkb(2, 8'h22, 1'b1));
    for (int c = 0; c < 20 && !i2creq; c++) smp();
    check("rst_issue_seen", 64'(i2creq), 64'(1));
    ak0 = n_ack;
    #2 rstn = 1'b0;
    pend.delete(); exp_q.delete();
    #1 check("rst_async", 64'({i2creq, ack_o, busy_o}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1; eng_en = 1'b1;
    smp(); smp();
    check("rst_no_ack", 64'(n_ack - ak0), 64'(0));
    run_vec(mkv(1'b0, 16'h1111, 8'hB0, 4'hF, 4'h0, 32'h0000_3210, 4'd4));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
